operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the register file in the RV32I core.
- Latches an incoming instruction and decodes rs1/rs2/rd and their usage.
- Drives the register-file read addresses and samples the asynchronous read data into an output pipeline register for execute.
- A 32-entry scoreboard of pending destinations, cleared by writeback, stalls RAW/WAW hazards.

Parameters:
- XLEN, 32, data/PC width; only 32 is supported.
- FLUSH_CLR_SB, 1, when 1, a flush clears the pending bit owned by the squashed output-register instruction.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  RV32I instruction word
- in_pc  in  XLEN  instruction PC
- rf_addr1  out  5  register-file read address 1 = in_instr[19:15]
- rf_addr2  out  5  register-file read address 2 = in_instr[24:20]
- rf_data1  in  XLEN  asynchronous read data 1 (x0 reads 0)
- rf_data2  in  XLEN  asynchronous read data 2
- wb_valid  in  1  writeback retiring this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  squash output register (branch redirect)
- out_valid  out  1  execute-side valid
- out_ready  in  1  execute-side ready
- out_pc, out_instr  out  XLEN/32  registered copies
- out_rs1_val, out_rs2_val  out  XLEN  operand values
- out_rd  out  5  destination index
- out_rd_wen  out  1  destination written (rd != 0)
- out_illegal  out  1  opcode not in supported set

Behaviour:
- Reset (sync, rst=1 at edge): out_valid=0, all out_* data=0, scoreboard=0. in_ready=0 while rst is high.
- Decode by opcode in_instr[6:0]:
  - LUI 0110111, AUIPC 0010111, JAL 1101111: rd only.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: rs1 and rd.
  - BRANCH 1100011, STORE 0100011: rs1 and rs2; no rd.
  - OP 0110011: rs1, rs2, and rd.
  - Any other opcode: no sources, no rd, illegal=1. It still passes through to execute.
- rd_wen = uses_rd && rd != 0.
- Unused sources read as 0 and never cause a hazard.
- A source hazard exists when the source is used, its index != 0, the pending bit is set, and no forwarding hit applies (see the optional feature).
- A WAW hazard exists when rd_wen is set and pending[rd] is set.
- stall = in_valid && (any source hazard || WAW hazard).
- in_ready = !rst && !flush && !stall && (!out_valid || out_ready). in_ready is combinational from in_instr; this is intended.
- Accept happens when in_valid && in_ready.
  - The output register loads on the next edge. Latency is 1 cycle.
  - Output value = forwarded wb_data if forwarding hits, else rf_data.
- If out_valid && out_ready && no accept, out_valid clears. If !out_ready, all outputs hold stable.
- Scoreboard update each edge:
  - wb_valid && wb_rd != 0 clears pending[wb_rd].
  - An accept with rd_wen sets pending[rd].
  - If both target the same index in one cycle, the set wins.
  - pending[0] is always 0.
- Flush (sync):
  - out_valid is 0 next cycle.
  - No accept occurs that cycle.
  - If FLUSH_CLR_SB=1 and out_valid && out_rd_wen, pending[out_rd] clears.
  - Writebacks in the same cycle still clear their bits.
- rst has priority over flush. rst mid-stall discards everything.

Optional Feature:
- Macro OFS_WB_FORWARD_EN.
- Defined: a forwarding hit occurs when wb_valid && wb_rd == source index (non-zero). That source takes wb_data and is not a hazard.
- Undefined: no forwarding. A pending source stalls until the cycle after its writeback, then reads the updated rf_data.

Test Plan:
- Reset, then present ADDI x5,x0,7 (0x00700293) at pc 0x100 with out_ready=1:
  - Next cycle out_valid=1, out_rd=5, out_rd_wen=1, out_rs1_val=0.
  - pending[5]=1.
- ADD x6,x5,x5 immediately after, with pending[5] set and no wb:
  - in_ready=0, and it holds.
  - Then wb_valid=1, wb_rd=5, wb_data=7.
  - With OFS_WB_FORWARD_EN: accepted that cycle, out_rs1_val=out_rs2_val=7.
  - Without it: accepted one cycle later with rf_data=7.
- Same-cycle wb_rd=6 clear and accept of ADDI x6 -> pending[6]=1 after the edge.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0. Then out_ready=1 -> new instruction loads on the next edge.
- Flush while out holds LUI x9 (out_rd_wen=1) -> next cycle out_valid=0 and pending[9]=0 (FLUSH_CLR_SB=1). Input is not accepted that cycle.
- Opcode 0x7F, rd=x3 -> out_illegal=1, out_rd_wen=0, no pending bit set. Writes to x0 (ADDI x0,x0,1) never set pending[0].

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - fetch/regfile/writeback/execute signal bundle for operand_fetch_stage
interface operand_fetch_stage_if #(
    parameter int XLEN = 32
);
    // upstream instruction handshake
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    // register-file read port (asynchronous data)
    logic [4:0]      rf_addr1;
    logic [4:0]      rf_addr2;
    logic [XLEN-1:0] rf_data1;
    logic [XLEN-1:0] rf_data2;

    // writeback retirement
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    // branch redirect
    logic            flush;

    // execute-side handshake and payload
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic            out_illegal;

    // environment side: fetch, register file, writeback and execute
    modport master (
        output in_valid, in_instr, in_pc,
        output rf_data1, rf_data2,
        output wb_valid, wb_rd, wb_data,
        output flush, out_ready,
        input  in_ready, rf_addr1, rf_addr2,
        input  out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val,
        input  out_rd, out_rd_wen, out_illegal
    );

    // stage side
    modport slave (
        input  in_valid, in_instr, in_pc,
        input  rf_data1, rf_data2,
        input  wb_valid, wb_rd, wb_data,
        input  flush, out_ready,
        output in_ready, rf_addr1, rf_addr2,
        output out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val,
        output out_rd, out_rd_wen, out_illegal
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - RV32I decode/operand-fetch stage with pending-destination scoreboard (optional writeback forwarding: OFS_WB_FORWARD_EN)
module operand_fetch_stage #(
    parameter int XLEN         = 32,
    parameter bit FLUSH_CLR_SB = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_fetch_stage_if.slave bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            uses_rd;
    logic            illegal;
    logic            rd_wen;
    logic            fwd1;
    logic            fwd2;
    logic            haz1;
    logic            haz2;
    logic            waw;
    logic            stall;
    logic            ready;
    logic            accept;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [31:0]     pending;
    logic [31:0]     pending_nxt;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];

    // The register file is addressed straight from the raw fields; unused
    // sources are masked on the data side instead.
    assign bus.rf_addr1 = rs1;
    assign bus.rf_addr2 = rs2;

    // Classify the opcode into which register fields it actually uses
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                uses_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign rd_wen = uses_rd && (rd != 5'd0);

`ifdef OFS_WB_FORWARD_EN
    // A retiring writeback to a source register satisfies it this cycle.
    assign fwd1 = uses_rs1 && (rs1 != 5'd0) && bus.wb_valid && (bus.wb_rd == rs1);
    assign fwd2 = uses_rs2 && (rs2 != 5'd0) && bus.wb_valid && (bus.wb_rd == rs2);
`else
    // Without forwarding the stage waits for the register file to be updated.
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign haz1  = uses_rs1 && (rs1 != 5'd0) && pending[rs1] && !fwd1;
    assign haz2  = uses_rs2 && (rs2 != 5'd0) && pending[rs2] && !fwd2;
    assign waw   = rd_wen && pending[rd];
    assign stall = bus.in_valid && (haz1 || haz2 || waw);

    // Ready depends on the decoded instruction itself, so it is combinational
    // from in_instr by design.
    assign ready        = !rst && !bus.flush && !stall && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = ready;
    assign accept       = bus.in_valid && ready;

    // Pick each operand: zero when unused or x0, forwarded value on a hit,
    // otherwise the register-file read data.
    always_comb begin
        op1 = bus.rf_data1;
        op2 = bus.rf_data2;
        if (!uses_rs1 || (rs1 == 5'd0)) begin
            op1 = '0;
        end else if (fwd1) begin
            op1 = bus.wb_data;
        end
        if (!uses_rs2 || (rs2 == 5'd0)) begin
            op2 = '0;
        end else if (fwd2) begin
            op2 = bus.wb_data;
        end
    end

    // Next scoreboard: writeback and flush clear, accept sets; the set is
    // applied last so it wins over a same-index clear.
    always_comb begin
        pending_nxt = pending;
        if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
            pending_nxt[bus.wb_rd] = 1'b0;
        end
        if (FLUSH_CLR_SB && bus.flush && bus.out_valid && bus.out_rd_wen) begin
            pending_nxt[bus.out_rd] = 1'b0;
        end
        if (accept && rd_wen) begin
            pending_nxt[rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Output pipeline register toward execute; holds while execute stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_pc      <= '0;
            bus.out_instr   <= '0;
            bus.out_rs1_val <= '0;
            bus.out_rs2_val <= '0;
            bus.out_rd      <= '0;
            bus.out_rd_wen  <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid   <= 1'b1;
            bus.out_pc      <= bus.in_pc;
            bus.out_instr   <= bus.in_instr;
            bus.out_rs1_val <= op1;
            bus.out_rs2_val <= op2;
            bus.out_rd      <= rd;
            bus.out_rd_wen  <= rd_wen;
            bus.out_illegal <= illegal;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed bench with behavioural reference model for operand_fetch_stage
module tb_operand_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_stage_if #(.XLEN(32)) ifc ();

    operand_fetch_stage #(.XLEN(32), .FLUSH_CLR_SB(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

`ifdef OFS_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] I_ADDI5  = 32'h0070_0293;
    localparam logic [31:0] I_ADD6   = 32'h0052_8333;
    localparam logic [31:0] I_ADDI6  = 32'h0010_0313;
    localparam logic [31:0] I_ADDI7  = 32'h0020_0393;
    localparam logic [31:0] I_LUI9   = 32'h1234_54B7;
    localparam logic [31:0] I_ADDI10 = 32'h0030_0513;
    localparam logic [31:0] I_ILL3   = 32'h0000_01FF;
    localparam logic [31:0] I_ADDI0  = 32'h0010_0013;
    localparam logic [31:0] I_SW     = 32'h0072_A023;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench register file: untouched registers read a recognisable pattern.
    logic [31:0] rf [32];
    logic [31:0] rf_written = '0;

    function automatic logic [31:0] rf_peek(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rf_written[a]) return rf[a];
        return 32'h1000_0000 | 32'(a);
    endfunction

    always_comb ifc.rf_data1 = rf_peek(ifc.rf_addr1);
    always_comb ifc.rf_data2 = rf_peek(ifc.rf_addr2);

    always @(posedge clk) begin
        if (ifc.wb_valid && ifc.wb_rd != 5'd0) begin
            rf[ifc.wb_rd]         <= ifc.wb_data;
            rf_written[ifc.wb_rd] <= 1'b1;
        end
    end

    // Reference model state
    bit          started = 1'b0;
    bit          m_valid;
    logic [31:0] m_pc, m_instr, m_rs1, m_rs2;
    logic [4:0]  m_rd;
    bit          m_wen, m_ill;
    logic [31:0] m_pend;

    // Instruction format usage: {illegal, reads rs1, reads rs2, writes rd}
    function automatic logic [3:0] usage(input logic [31:0] ins);
        case (ins[6:0])
            7'h37, 7'h17, 7'h6F: return 4'b0001;
            7'h67, 7'h03, 7'h13: return 4'b0101;
            7'h63, 7'h23:        return 4'b0110;
            7'h33:               return 4'b0111;
            default:             return 4'b1000;
        endcase
    endfunction

    function automatic bit fwd_hit(input logic [4:0] idx);
        return FWD && ifc.wb_valid && (idx != 5'd0) && (ifc.wb_rd == idx);
    endfunction

    function automatic bit blocked(input bit used, input logic [4:0] idx);
        return used && (idx != 5'd0) && m_pend[idx] && !fwd_hit(idx);
    endfunction

    function automatic bit m_ready();
        logic [3:0] u;
        logic [4:0] d;
        bit         wen;
        bit         hold;
        u    = usage(ifc.in_instr);
        d    = ifc.in_instr[11:7];
        wen  = u[0] && (d != 5'd0);
        hold = ifc.in_valid && (blocked(u[2], ifc.in_instr[19:15]) ||
                                blocked(u[1], ifc.in_instr[24:20]) ||
                                (wen && m_pend[d]));
        return !rst && !ifc.flush && !hold && (!m_valid || ifc.out_ready);
    endfunction

    function automatic logic [31:0] src_val(input bit used, input logic [4:0] idx);
        if (!used || idx == 5'd0) return 32'd0;
        if (fwd_hit(idx)) return ifc.wb_data;
        return rf_peek(idx);
    endfunction

    // Model: advance expected outputs and pending set on every rising edge
    always @(posedge clk) begin
        logic [3:0]  u;
        logic [31:0] np;
        logic [4:0]  d;
        bit          acc;
        started = 1'b1;
        if (rst) begin
            m_valid = 1'b0; m_pc = '0; m_instr = '0; m_rs1 = '0; m_rs2 = '0;
            m_rd = '0; m_wen = 1'b0; m_ill = 1'b0; m_pend = '0;
        end else begin
            u   = usage(ifc.in_instr);
            d   = ifc.in_instr[11:7];
            acc = ifc.in_valid && m_ready();
            np  = m_pend;
            if (ifc.wb_valid && ifc.wb_rd != 5'd0) np[ifc.wb_rd] = 1'b0;
            if (ifc.flush && m_valid && m_wen) np[m_rd] = 1'b0;
            if (acc && u[0] && d != 5'd0) np[d] = 1'b1;
            np[0] = 1'b0;
            if (ifc.flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_pc    = ifc.in_pc;
                m_instr = ifc.in_instr;
                m_rs1   = src_val(u[2], ifc.in_instr[19:15]);
                m_rs2   = src_val(u[1], ifc.in_instr[24:20]);
                m_rd    = d;
                m_wen   = u[0] && (d != 5'd0);
                m_ill   = u[3];
            end else if (m_valid && ifc.out_ready) begin
                m_valid = 1'b0;
            end
            m_pend = np;
        end
    end

    // Compare DUT against the model mid-cycle
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",    32'(ifc.in_ready),   32'(m_ready()));
            chk("out_valid",   32'(ifc.out_valid),  32'(m_valid));
            chk("out_pc",      ifc.out_pc,          m_pc);
            chk("out_instr",   ifc.out_instr,       m_instr);
            chk("out_rs1_val", ifc.out_rs1_val,     m_rs1);
            chk("out_rs2_val", ifc.out_rs2_val,     m_rs2);
            chk("out_rd",      32'(ifc.out_rd),     32'(m_rd));
            chk("out_rd_wen",  32'(ifc.out_rd_wen), 32'(m_wen));
            chk("out_illegal", 32'(ifc.out_illegal), 32'(m_ill));
            chk("pending",     dut.pending,         m_pend);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic put(input bit v, input logic [31:0] ins, input logic [31:0] pc);
        ifc.in_valid = v;
        ifc.in_instr = ins;
        ifc.in_pc    = pc;
    endtask

    task automatic wb(input bit v, input logic [4:0] r, input logic [31:0] d);
        ifc.wb_valid = v;
        ifc.wb_rd    = r;
        ifc.wb_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        put(1'b0, 32'd0, 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        ifc.flush     = 1'b0;
        ifc.out_ready = 1'b1;
        rst           = 1'b1;

        // reset, with an instruction already offered
        tick();
        put(1'b1, I_ADDI5, 32'h100);
        tick(); settle();
        chk("lit rst in_ready", 32'(ifc.in_ready), 32'd0);
        chk("lit rst out_valid", 32'(ifc.out_valid), 32'd0);
        chk("lit rst pending", dut.pending, 32'd0);

        // ADDI x5,x0,7 accepted once reset drops
        tick();
        rst = 1'b0;
        settle();
        chk("lit addi in_ready", 32'(ifc.in_ready), 32'd1);
        tick();
        put(1'b1, I_ADD6, 32'h104);
        settle();
        chk("lit addi out_valid", 32'(ifc.out_valid), 32'd1);
        chk("lit addi out_rd", 32'(ifc.out_rd), 32'd5);
        chk("lit addi out_rd_wen", 32'(ifc.out_rd_wen), 32'd1);
        chk("lit addi rs1", ifc.out_rs1_val, 32'd0);
        chk("lit addi pc", ifc.out_pc, 32'h100);
        chk("lit addi p5", 32'(dut.pending[5]), 32'd1);
        chk("lit model p5", 32'(m_pend[5]), 32'd1);
        chk("lit add raw stall", 32'(ifc.in_ready), 32'd0);

        // ADD x6,x5,x5 held until x5 retires
        tick(); settle();
        chk("lit add still stalled", 32'(ifc.in_ready), 32'd0);
        tick();
        wb(1'b1, 5'd5, 32'd7);
        settle();
        chk("lit add wb cycle ready", 32'(ifc.in_ready), 32'(FWD));
        tick();
        wb(1'b0, 5'd0, 32'd0);
        if (!FWD) begin
            settle();
            chk("lit add after wb ready", 32'(ifc.in_ready), 32'd1);
            tick();
        end
        settle();
        chk("lit add out_valid", 32'(ifc.out_valid), 32'd1);
        chk("lit add rs1", ifc.out_rs1_val, 32'd7);
        chk("lit add rs2", ifc.out_rs2_val, 32'd7);
        chk("lit add rd", 32'(ifc.out_rd), 32'd6);
        chk("lit add p6", 32'(dut.pending[6]), 32'd1);
        chk("lit add p5 cleared", 32'(dut.pending[5]), 32'd0);

        // ADDI x6: WAW stall, then same-cycle clear and set of x6
        tick();
        put(1'b1, I_ADDI6, 32'h108);
        wb(1'b1, 5'd6, 32'h66);
        settle();
        chk("lit waw stall", 32'(ifc.in_ready), 32'd0);
        tick();
        wb(1'b1, 5'd6, 32'h77);
        settle();
        chk("lit waw cleared ready", 32'(ifc.in_ready), 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        put(1'b1, I_ADDI7, 32'h10C);
        ifc.out_ready = 1'b0;
        settle();
        chk("lit set wins p6", 32'(dut.pending[6]), 32'd1);
        chk("lit model p6", 32'(m_pend[6]), 32'd1);

        // execute back-pressure: outputs frozen, nothing accepted
        chk("lit bp instr", ifc.out_instr, I_ADDI6);
        chk("lit bp in_ready", 32'(ifc.in_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            chk("lit bp hold valid", 32'(ifc.out_valid), 32'd1);
            chk("lit bp hold instr", ifc.out_instr, I_ADDI6);
            chk("lit bp hold ready", 32'(ifc.in_ready), 32'd0);
        end
        tick();
        ifc.out_ready = 1'b1;
        settle();
        chk("lit bp release ready", 32'(ifc.in_ready), 32'd1);
        tick(); settle();
        chk("lit bp new instr", ifc.out_instr, I_ADDI7);
        chk("lit p7", 32'(dut.pending[7]), 32'd1);

        // flush squashes LUI x9 and releases its pending bit
        tick();
        put(1'b1, I_LUI9, 32'h200);
        settle();
        chk("lit lui ready", 32'(ifc.in_ready), 32'd1);
        tick();
        put(1'b1, I_ADDI10, 32'h204);
        ifc.flush     = 1'b1;
        ifc.out_ready = 1'b0;
        settle();
        chk("lit lui out_rd", 32'(ifc.out_rd), 32'd9);
        chk("lit lui wen", 32'(ifc.out_rd_wen), 32'd1);
        chk("lit flush in_ready", 32'(ifc.in_ready), 32'd0);
        tick();
        ifc.flush     = 1'b0;
        ifc.out_ready = 1'b1;
        put(1'b0, 32'd0, 32'd0);
        settle();
        chk("lit flush out_valid", 32'(ifc.out_valid), 32'd0);
        chk("lit flush p9", 32'(dut.pending[9]), 32'd0);
        chk("lit flush p10", 32'(dut.pending[10]), 32'd0);

        // illegal opcode and a write to x0
        tick();
        put(1'b1, I_ILL3, 32'h300);
        settle();
        chk("lit ill ready", 32'(ifc.in_ready), 32'd1);
        tick();
        put(1'b1, I_ADDI0, 32'h304);
        settle();
        chk("lit ill flag", 32'(ifc.out_illegal), 32'd1);
        chk("lit ill wen", 32'(ifc.out_rd_wen), 32'd0);
        chk("lit ill p3", 32'(dut.pending[3]), 32'd0);
        tick();
        put(1'b0, 32'd0, 32'd0);
        settle();
        chk("lit x0 instr", ifc.out_instr, I_ADDI0);
        chk("lit x0 wen", 32'(ifc.out_rd_wen), 32'd0);
        chk("lit x0 illegal", 32'(ifc.out_illegal), 32'd0);
        chk("lit x0 p0", 32'(dut.pending[0]), 32'd0);

        // store stalls on x7, reset mid-stall discards the scoreboard
        tick();
        put(1'b1, I_SW, 32'h308);
        settle();
        chk("lit sw stall", 32'(ifc.in_ready), 32'd0);
        tick();
        rst = 1'b1;
        settle();
        chk("lit rst mid ready", 32'(ifc.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("lit rst mid pending", dut.pending, 32'd0);
        chk("lit rst mid valid", 32'(ifc.out_valid), 32'd0);
        chk("lit sw ready", 32'(ifc.in_ready), 32'd1);
        tick();
        put(1'b0, 32'd0, 32'd0);
        settle();
        chk("lit sw rs1", ifc.out_rs1_val, 32'd7);
        chk("lit sw rs2", ifc.out_rs2_val, 32'h1000_0007);
        chk("lit sw wen", 32'(ifc.out_rd_wen), 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
